// File: rtl/fram_axis_packer_if.sv
// AXI-Stream beat channel between the frame packer and the DMA S2MM slave.
interface fram_axis_packer_if;
    logic [31:0] tdata;
    logic [3:0]  tkeep;
    logic        tlast;
    logic        tvalid;
    logic        tready;

    modport master (output tdata, tkeep, tlast, tvalid, input tready);
    modport slave  (input tdata, tkeep, tlast, tvalid, output tready);
endinterface

// File: rtl/fram_axis_packer.sv
// Packs frame-readout samples into 32-bit AXI-Stream beats through a small beat FIFO,
// with per-frame tlast/tkeep, overflow accounting and address-sequence checking.
module fram_axis_packer #(
    parameter int DATA_SIZE   = 12,
    parameter int LENGTH      = 32768,
    parameter int LENGTH_SIZE = 15,
    parameter int PACK        = 2,
    parameter int FIFO_DEPTH  = 16,
    parameter int FIFO_ADD    = 4
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   Enable,
    input  logic [DATA_SIZE-1:0]   FramData,
    input  logic [LENGTH_SIZE-1:0] FramAdd,
    input  logic                   FramEn,
    fram_axis_packer_if.master     m_axis,
    output logic                   Busy,
    output logic                   Overflow,
    output logic                   SeqErr,
    output logic [15:0]            DropCount,
    output logic                   FrameDone,
    input  logic                   ClrStatus
);

    localparam int LANE_W     = 32 / PACK;
    localparam int LANE_BYTES = LANE_W / 8;
    localparam int CNT_W      = FIFO_ADD + 1;
    localparam logic [LENGTH_SIZE-1:0] LAST_ADD  = LENGTH_SIZE'(LENGTH - 1);
    localparam logic [1:0]             LAST_LANE = 2'(PACK - 1);

    typedef enum logic [1:0] {IDLE, WAIT_SOF, RUN} state_t;

    typedef struct packed {
        logic        last;
        logic [3:0]  keep;
        logic [31:0] data;
    } beat_t;

    state_t                 state, state_nxt;
    logic                   accept, is_last, close_beat, seq_mismatch;
    logic [31:0]            beat_nxt, beat_acc;
    logic [3:0]             keep_nxt;
    logic [1:0]             lane_idx;
    logic [LENGTH_SIZE-1:0] exp_idx;
    logic                   stage_valid;
    beat_t                  stage_beat;

    beat_t                  mem [FIFO_DEPTH];
    beat_t                  head;
    logic [FIFO_ADD-1:0]    wr_ptr, rd_ptr;
    logic [CNT_W-1:0]       count;
    logic                   fifo_empty, fifo_full, rd_fire, wr_fire, drop;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= state_nxt;
    end

    // NOTE: every combinational output gets a default first so no path infers a latch.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        unique case (state)
            IDLE:     if (Enable) state_nxt = WAIT_SOF;
            WAIT_SOF: begin
                if (!Enable) begin
                    state_nxt = IDLE;
                end else if (FramEn && FramAdd == '0) begin
                    accept    = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN:      accept = FramEn;
            default:  state_nxt = IDLE;
        endcase
        is_last = accept && (FramAdd == LAST_ADD);
        if (is_last) state_nxt = Enable ? WAIT_SOF : IDLE;

        seq_mismatch = accept && (state == RUN) && (FramAdd != exp_idx);
        close_beat   = accept && (is_last || lane_idx == LAST_LANE);
        beat_nxt     = ((lane_idx == 2'd0) ? 32'd0 : beat_acc)
                     | (32'(FramData) << (LANE_W * int'(lane_idx)));
        keep_nxt     = 4'hF >> (4 - LANE_BYTES * (int'(lane_idx) + 1));
    end

    // Lane 0 starts from zero, so unfilled lanes of a short last beat read as 0.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            lane_idx    <= '0;
            beat_acc    <= '0;
            exp_idx     <= '0;
            stage_valid <= 1'b0;
            stage_beat  <= '0;
        end else begin
            stage_valid <= close_beat;
            if (accept) begin
                exp_idx <= is_last ? '0 : FramAdd + LENGTH_SIZE'(1);
                if (close_beat) begin
                    stage_beat <= '{last: is_last, keep: keep_nxt, data: beat_nxt};
                    lane_idx   <= '0;
                end else begin
                    beat_acc <= beat_nxt;
                    lane_idx <= lane_idx + 2'd1;
                end
            end
        end
    end

    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == CNT_W'(FIFO_DEPTH));
    assign rd_fire    = m_axis.tvalid && m_axis.tready;
    assign wr_fire    = stage_valid && (!fifo_full || rd_fire);
    assign drop       = stage_valid && fifo_full && !rd_fire;

    // NOTE: the beat storage has no reset; the outputs are gated by fifo_empty so stale
    // entries are never visible after a reset.
    always_ff @(posedge clk) begin
        if (wr_fire) mem[wr_ptr] <= stage_beat;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_fire) wr_ptr <= wr_ptr + FIFO_ADD'(1);
            if (rd_fire) rd_ptr <= rd_ptr + FIFO_ADD'(1);
            unique case ({wr_fire, rd_fire})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    assign head          = mem[rd_ptr];
    assign m_axis.tvalid = !fifo_empty;
    assign m_axis.tdata  = fifo_empty ? 32'd0 : head.data;
    assign m_axis.tkeep  = fifo_empty ? 4'd0  : head.keep;
    assign m_axis.tlast  = !fifo_empty && head.last;
    assign Busy          = (state != IDLE) || !fifo_empty;

    // A clear in the same cycle as a drop or sequence error wins.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            Overflow  <= 1'b0;
            SeqErr    <= 1'b0;
            DropCount <= '0;
            FrameDone <= 1'b0;
        end else begin
            FrameDone <= rd_fire && head.last;
            if (ClrStatus) begin
                Overflow  <= 1'b0;
                SeqErr    <= 1'b0;
                DropCount <= '0;
            end else begin
                if (drop) begin
                    Overflow <= 1'b1;
                    if (DropCount != 16'hFFFF) DropCount <= DropCount + 16'd1;
                end
                if (seq_mismatch) SeqErr <= 1'b1;
            end
        end
    end

endmodule
